inst_fetch_port: RTL
====================

Name: inst_fetch_port

Overview:
- Responder side of the instruction-fetch interface.
- Accepts the fetch request (ce, pc) driven by the PC stage and returns the 32-bit instruction word to the IF/ID stage.
- Fetches from a wait-stated instruction memory bus with a req/ack handshake, holding the last fetched word in a one-entry buffer.
- Raises stallreq to the pipeline control block while a fetch is outstanding.

Parameters:
- ADDR_W, 32, width of pc and mem_addr.
- DATA_W, 32, width of instruction and mem_rdata.
- TIMEOUT, 255, max cycles waiting for mem_ack before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  fetch enable from the PC stage; 0 = chip disabled.
- pc  in  ADDR_W  fetch byte address from the PC stage.
- inv  in  1  invalidate buffer (one-cycle pulse).
- inst  out  DATA_W  instruction to IF/ID; combinational.
- stallreq  out  1  stall request to pipeline control; combinational.
- fetch_err  out  1  one-cycle pulse on timeout abort; registered.
- mem_req  out  1  memory read request; registered.
- mem_addr  out  ADDR_W  word-aligned read address; registered.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  read completion; sampled only while mem_req=1.

Behaviour:
- Reset: clk and rst are the clock and reset; reset is synchronous and active-high.
  - rst=1 at a rising edge sets state=IDLE, mem_req=0, mem_addr=0, fetch_err=0, buf_valid=0, buf_addr=0, buf_data=0 and wait counter=0.
  - Reset mid-transaction abandons the request; a late mem_ack is ignored because mem_req=0.
- Hit: hit = ce & buf_valid & (buf_addr == pc[ADDR_W-1:2]). pc[1:0] is ignored everywhere.
- inst: equals buf_data when hit, else 0 (NOP).
- stallreq: equals ce & ~hit. With ce=0, inst=0 and stallreq=0.
- FSM states: IDLE, REQ.
- IDLE:
  - If ce & ~hit & ~inv: mem_req<=1, mem_addr<={pc[ADDR_W-1:2],2'b00}, counter<=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ: mem_req and mem_addr are held stable until completion; the transaction is never aborted by ce or pc changes.
  - mem_ack=1: buf_data<=mem_rdata, buf_addr<=mem_addr[ADDR_W-1:2], buf_valid<=1, mem_req<=0, go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: mem_req<=0, fetch_err<=1 for one cycle, buf_valid<=0, go to IDLE. The fetch is retried if the miss persists.
  - Else counter<=counter+1.
- inv:
  - In IDLE: buf_valid<=0 next edge.
  - In REQ: the transaction completes on the bus, but the buffer fill for it is suppressed (buf_valid<=0).
  - inv and mem_ack in the same cycle: inv wins.
- Latency: miss on pc at cycle 0 → mem_req=1 in cycle 1.
  - mem_ack in cycle k≥1 → hit and inst valid in cycle k+1.
  - Minimum stall is 2 cycles.
- Wrap-around: the wait counter is ceil(log2(TIMEOUT+1)) bits and never wraps, because timeout triggers first.
- pc changed during REQ (branch): the old fill completes and lands in the buffer; the next cycle misses and a new request is issued.

Test Plan:
- Reset then ce=0, pc=0 for 5 cycles → inst=0, stallreq=0, mem_req=0 throughout.
- ce=1, pc=0x00000004, mem_ack returned 1 cycle after mem_req with rdata=0x34011100 → mem_addr=0x00000004, stallreq high 2 cycles, then inst=0x34011100, stallreq=0.
- Repeat same pc=0x00000006 after a fill → hit, no mem_req, inst=buffered word (low bits ignored).
- TIMEOUT=4, mem_ack never asserted → mem_req high exactly 4 cycles, fetch_err pulses once, new mem_req issued on the next cycle.
- inv pulsed in the same cycle as mem_ack (rdata=0xDEADBEEF) → buffer not filled, stallreq stays 1, new request to the same address.
- rst asserted while mem_req=1, mem_ack arrives 1 cycle later → mem_req=0 after reset, ack ignored, buf_valid=0, inst=0.

Source files
------------

// File: rtl/inst_fetch_port.sv
// ============================================================================
//  inst_fetch_port : instruction-fetch responder with a one-entry word buffer
//  Revision 1.0
// ============================================================================
`default_nettype none

module inst_fetch_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              inv,
  output logic [DATA_W-1:0] inst,
  output logic              stallreq,
  output logic              fetch_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_fetch_err;
  logic                r_buf_valid;
  logic [ADDR_W-3:0]   r_buf_addr;
  logic [DATA_W-1:0]   r_buf_data;
  logic [c_CNT_W-1:0]  r_cnt;
  // Set by an invalidate seen while the bus read is in flight, so its data is dropped.
  logic                r_kill;

  logic                w_hit;
  logic                w_unused_pc_lsb;

  assign w_hit           = ce & r_buf_valid & (r_buf_addr == pc[ADDR_W-1:2]);
  assign w_unused_pc_lsb = &{1'b0, pc[1:0]};

  assign inst      = w_hit ? r_buf_data : '0;
  assign stallreq  = ce & ~w_hit;
  assign fetch_err = r_fetch_err;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_fetch_err <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_cnt       <= '0;
      r_kill      <= 1'b0;
    end else begin
      r_fetch_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (inv) begin
            r_buf_valid <= 1'b0;
          end else if (ce && !w_hit) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {pc[ADDR_W-1:2], 2'b00};
            r_cnt      <= '0;
            r_kill     <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (inv) begin
            r_kill      <= 1'b1;
            r_buf_valid <= 1'b0;
          end
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
            if (!(inv || r_kill)) begin
              r_buf_data  <= mem_rdata;
              r_buf_addr  <= r_mem_addr[ADDR_W-1:2];
              r_buf_valid <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
            r_mem_req   <= 1'b0;
            r_fetch_err <= 1'b1;
            r_buf_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
